button_conditioner: RTL and testbench
=====================================

# button_conditioner

Conditions one raw board push-button or switch into clean, clock-synchronous control events for the counter and display logic. It synchronizes, debounces, and classifies the input into a debounced level plus one-cycle press, release, long-press and auto-repeat pulses. Every button that currently feeds design logic raw (e.g. the step button into the counters) goes through one instance in the top level.

## Interface
- `CLKFREQ`, 27000000 — clock frequency in Hz; sets the cycle counts below.
- `ACTIVE_LOW`, 1 — 1: `btn_raw` low means pressed (Tang Nano buttons); 0: high means pressed.
- `DEBOUNCE_MS`, 10 — stability time before the level changes; `DB_CYC = CLKFREQ/1000*DEBOUNCE_MS`, must be ≥1.
- `LONG_MS`, 600 — hold time before `long_press`; `LONG_CYC` derived the same way, must be ≥1.
- `REPEAT_MS`, 100 — auto-repeat period after a long press; `REP_CYC` derived the same way, must be ≥1.

Ports:
- `clk` input 1 — single clock, all logic on rising edge.
- `rst_n` input 1 — **one clock; reset is asynchronous and active-low.**
- `btn_raw` input 1 — asynchronous pin, may bounce.
- `level` output 1 — debounced state, 1 = pressed.
- `press` output 1 — one-cycle pulse on the debounced press.
- `release` output 1 — one-cycle pulse on the debounced release.
- `long_press` output 1 — one-cycle pulse once per hold, after `LONG_CYC` cycles held.
- `repeat` output 1 — one-cycle pulse every `REP_CYC` cycles after `long_press` while held.
- `step` output 1 — `press | repeat`; registered, so it is glitch-free.

## Operation
- Input is normalized: `pressed_raw = btn_raw ^ ACTIVE_LOW`.
- It then passes through a 2-flop synchronizer, giving `s`. Both flops reset to 0 (released).
- Debounce:
  - The counter `db_cnt` increments each cycle while `s != level`.
  - It clears to 0 on any cycle where `s == level`, so bounce restarts the count.
  - When `db_cnt == DB_CYC-1` and `s != level`, `level` toggles on that edge and `db_cnt` clears.
- FSM states:
  - IDLE: `level` = 0.
  - HELD: pressed, long press not yet reached.
  - REPEAT: long press reached.
- Transitions:
  - IDLE→HELD on the level rise. `press` = 1 that cycle and the hold timer clears.
  - HELD: the timer counts each cycle. At `LONG_CYC-1`, go to REPEAT, pulse `long_press` and clear the timer.
  - REPEAT: the timer counts. At `REP_CYC-1`, pulse `repeat` and clear the timer, indefinitely.
  - HELD or REPEAT→IDLE on the level fall. `release` = 1 and all other pulses are suppressed that cycle.
- The timer width is `$clog2(max(LONG_CYC,REP_CYC))`. It never wraps; it clears exactly at terminal count.
- A release before `LONG_CYC` produces `press` and `release` only, with no `long_press`.
- Reset mid-hold: all outputs go to 0 immediately (async). After reset, a still-held button is seen as a fresh press after sync + debounce.

## Timing
- Reset values: `level`, `press`, `release`, `long_press`, `repeat`, `step`, FSM = IDLE, and all counters are 0.
- Press latency, from the first edge where the pin is sampled pressed and then stays stable:
  - `level` and `press` assert 2 + `DB_CYC` cycles later.
  - `step` asserts on the same cycle as `press`.
- Release latency is the same: 2 + `DB_CYC` cycles after a stable release.
- `long_press` asserts exactly `LONG_CYC` cycles after `press`.
- The first `repeat` is `REP_CYC` cycles after `long_press`, then every `REP_CYC` cycles.
- All pulses last exactly one cycle. At most one of `press`, `release`, `long_press`, `repeat` is high in any cycle.

## Structure
- The shared board package/include holds:
  - the `ms_to_cycles(freq, ms)` constant function;
  - the FSM state encoding localparams (IDLE=0, HELD=1, REPEAT=2).
- Sub-module `sync2` is the reusable 2-flop synchronizer with async active-low reset and a reset-value parameter. It is also reused for the switch inputs.

## Test plan
All scenarios use `CLKFREQ`=1000, `DEBOUNCE_MS`=4, `LONG_MS`=20, `REPEAT_MS`=5, `ACTIVE_LOW`=1.
- **Reset:** hold `rst_n`=0 with `btn_raw`=0 → all outputs stay 0. Release reset with the button still held → `press` fires 6 cycles after `rst_n` rises.
- **Clean short press:** `btn_raw` low for 10 cycles, then high → `press` at +6, `release` 6 cycles after the rise, no `long_press`, `step` = `press`.
- **Bounce:** toggle `btn_raw` every 2 cycles for 12 cycles, then hold low → exactly one `press`, 6 cycles after the final stable low.
- **Long hold:** low for 50 cycles → `long_press` 20 cycles after `press`, `repeat` at +25/+30/+35/+40 from `press`, each also on `step`, then `release`.
- **Glitch rejection:** a 3-cycle low pulse (shorter than `DB_CYC`) → `level` stays 0 and no pulses occur.
- **Async reset mid-REPEAT:** assert `rst_n` between clock edges → outputs clear without waiting for a clock edge, and the FSM is in IDLE on the next edge.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared board helpers: millisecond-to-cycle conversion, counter sizing and
// the button FSM state encoding.
`timescale 1ns/1ps
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Converts a duration in milliseconds into clock cycles at freq Hz.
    function automatic int ms_to_cycles(input int freq, input int ms);
        return freq / 1000 * ms;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_conditioner_sync2.sv
// Reusable two-flop synchronizer for asynchronous pins (buttons, switches).
`timescale 1ns/1ps
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first one a full cycle to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            // NOTE: non-blocking keeps this a two-stage shift; blocking would collapse it to one flop.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Turns one raw, bouncing push-button into a debounced level plus one-cycle
// press / release / long-press / auto-repeat pulses and a combined step pulse.
// release_evt and repeat_evt carry the release and repeat pulses; the bare
// words are reserved keywords in SystemVerilog.
`timescale 1ns/1ps
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int CLKFREQ     = 27000000,
    parameter int ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 600,
    parameter int REPEAT_MS   = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic release_evt,
    output logic long_press,
    output logic repeat_evt,
    output logic step
);

    localparam int DB_CYC   = ms_to_cycles(CLKFREQ, DEBOUNCE_MS);
    localparam int LONG_CYC = ms_to_cycles(CLKFREQ, LONG_MS);
    localparam int REP_CYC  = ms_to_cycles(CLKFREQ, REPEAT_MS);
    localparam int DB_W     = cnt_width(DB_CYC);
    localparam int TMR_W    = cnt_width(max_int(LONG_CYC, REP_CYC));

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYC - 1);
    localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYC - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REP_CYC - 1);

    logic             pressed_raw;
    logic             s;
    logic             db_level;
    logic [DB_W-1:0]  db_cnt;
    logic [TMR_W-1:0] tmr;
    state_t           state;

    // Normalise polarity so that 1 always means pressed from here on.
    assign pressed_raw = btn_raw ^ (ACTIVE_LOW != 0);

    sync2 #(
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pressed_raw),
        .q     (s)
    );

    // Debounce: the level flips only after DB_CYC consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (s == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            db_level <= ~db_level;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Classifier FSM with registered outputs, one cycle behind the debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            tmr         <= '0;
            level       <= 1'b0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
            step        <= 1'b0;
        end else begin
            level       <= db_level;
            // NOTE: pulses default low every cycle, so any assignment below lasts exactly one cycle.
            press       <= 1'b0;
            release_evt <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
            step        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (db_level) begin
                        state <= ST_HELD;
                        tmr   <= '0;
                        press <= 1'b1;
                        step  <= 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!db_level) begin
                        state       <= ST_IDLE;
                        tmr         <= '0;
                        release_evt <= 1'b1;
                    end else if (tmr == LONG_LAST) begin
                        state      <= ST_REPEAT;
                        tmr        <= '0;
                        long_press <= 1'b1;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!db_level) begin
                        state       <= ST_IDLE;
                        tmr         <= '0;
                        release_evt <= 1'b1;
                    end else if (tmr == REP_LAST) begin
                        tmr        <= '0;
                        repeat_evt <= 1'b1;
                        step       <= 1'b1;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tmr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a fast clock
// (1 kHz nominal: DB=4, LONG=20, REPEAT=5 cycles).
`timescale 1ns/1ps
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    localparam int CLKFREQ     = 1000;
    localparam int ACTIVE_LOW  = 1;
    localparam int DEBOUNCE_MS = 4;
    localparam int LONG_MS     = 20;
    localparam int REPEAT_MS   = 5;
    localparam int DB_CYC      = 4;
    localparam int LONG_CYC    = 20;
    localparam int REP_CYC     = 5;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic btn_raw = 1'b0;
    logic level, press, release_evt, long_press, repeat_evt, step;

    button_conditioner #(
        .CLKFREQ     (CLKFREQ),
        .ACTIVE_LOW  (ACTIVE_LOW),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .LONG_MS     (LONG_MS),
        .REPEAT_MS   (REPEAT_MS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .level       (level),
        .press       (press),
        .release_evt (release_evt),
        .long_press  (long_press),
        .repeat_evt  (repeat_evt),
        .step        (step)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Edge counter: number of rising edges seen so far.
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    // ---------------- behavioural model ----------------
    // Debounced value flips once the last DB_CYC pin samples (seen through the
    // 2-flop delay) all disagree with it; outputs follow one cycle later, and
    // the hold pulses are derived from the number of cycles since press.
    bit          hist[$];
    bit          m_db    = 1'b0;
    bit          m_level = 1'b0;
    int          m_hold  = 0;
    logic [5:0]  exp_vec = '0;   // {level, press, release, long, repeat, step}

    task automatic model_reset();
        hist.delete();
        m_db    = 1'b0;
        m_level = 1'b0;
        m_hold  = 0;
        exp_vec = '0;
    endtask

    task automatic model_step();
        bit prev_db = m_db;
        bit e_press = 1'b0, e_rel = 1'b0, e_long = 1'b0, e_rpt = 1'b0;
        int n;
        bit all_diff;
        if (prev_db && !m_level) begin
            e_press = 1'b1;
            m_hold  = 0;
        end else if (!prev_db && m_level) begin
            e_rel = 1'b1;
        end else if (prev_db) begin
            m_hold++;
            if (m_hold == LONG_CYC) e_long = 1'b1;
            else if (m_hold > LONG_CYC && ((m_hold - LONG_CYC) % REP_CYC) == 0) e_rpt = 1'b1;
        end
        m_level = prev_db;
        exp_vec = {m_level, e_press, e_rel, e_long, e_rpt, e_press | e_rpt};
        hist.push_back(btn_raw ^ 1'b1);
        n = hist.size() - 1;
        if (n >= DB_CYC + 1) begin
            all_diff = 1'b1;
            for (int i = n - DB_CYC - 1; i <= n - 2; i++)
                if (hist[i] == m_db) all_diff = 1'b0;
            if (all_diff) m_db = ~m_db;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Compare every cycle, half a period after the active edge.
    always @(negedge clk) begin
        check($sformatf("outputs@edge%0d", edge_cnt),
              {26'd0, level, press, release_evt, long_press, repeat_evt, step},
              {26'd0, exp_vec});
    end

    // ---------------- event recorder ----------------
    int mark = 0;
    int n_press, n_rel, n_long, n_step, n_level;
    int t_press, t_rel, t_long;
    int rep_q[$];

    task automatic clear_rec();
        n_press = 0; n_rel = 0; n_long = 0; n_step = 0; n_level = 0;
        t_press = -1; t_rel = -1; t_long = -1;
        rep_q.delete();
    endtask

    always @(negedge clk) begin
        if (press)       begin n_press++; t_press = edge_cnt; end
        if (release_evt) begin n_rel++;   t_rel   = edge_cnt; end
        if (long_press)  begin n_long++;  t_long  = edge_cnt; end
        if (repeat_evt)  rep_q.push_back(edge_cnt);
        if (step)        n_step++;
        if (level)       n_level++;
    end

    // Cycles from the first sampling edge after 'mark' to the event edge.
    function automatic int rel(input int abs_edge, input int m);
        return (abs_edge < 0) ? -1 : abs_edge - m - 1;
    endfunction

    function automatic int rep_at(input int idx);
        return (idx < rep_q.size()) ? rel(rep_q[idx], mark) : -1;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m2;
        clear_rec();
        // Reset held with the button pressed: nothing may come out.
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        cycles(5);
        check("reset_outputs", {26'd0, level, press, release_evt, long_press, repeat_evt, step}, 32'd0);
        check("reset_no_level", n_level, 0);

        // Leave reset with the button still held: fresh press 6 cycles later.
        clear_rec();
        mark  = edge_cnt;
        rst_n = 1'b1;
        cycles(10);
        check("rst_press_count", n_press, 1);
        check("rst_press_time", rel(t_press, mark), 6);
        check("rst_step_count", n_step, 1);
        clear_rec();
        mark    = edge_cnt;
        btn_raw = 1'b1;
        cycles(10);
        check("rst_release_time", rel(t_rel, mark), 6);

        // Clean short press: 10 cycles low.
        cycles(5);
        clear_rec();
        mark    = edge_cnt;
        btn_raw = 1'b0;
        cycles(10);
        m2      = edge_cnt;
        btn_raw = 1'b1;
        cycles(12);
        check("short_press_time", rel(t_press, mark), 6);
        check("short_release_time", rel(t_rel, m2), 6);
        check("short_no_long", n_long, 0);
        check("short_no_repeat", rep_q.size(), 0);
        check("short_step_count", n_step, 1);

        // Bounce: 2-cycle toggles for 12 cycles, then a stable low.
        cycles(5);
        clear_rec();
        for (int k = 0; k < 6; k++) begin
            btn_raw = (k % 2 == 0) ? 1'b0 : 1'b1;
            cycles(2);
        end
        mark    = edge_cnt;
        btn_raw = 1'b0;
        cycles(10);
        check("bounce_press_count", n_press, 1);
        check("bounce_press_time", rel(t_press, mark), 6);
        btn_raw = 1'b1;
        cycles(12);
        check("bounce_release_count", n_rel, 1);

        // Long hold: 50 cycles low. The repeat due at +56 coincides with release
        // and is suppressed, leaving five repeats.
        cycles(5);
        clear_rec();
        mark    = edge_cnt;
        btn_raw = 1'b0;
        cycles(50);
        btn_raw = 1'b1;
        cycles(12);
        check("long_press_time", rel(t_press, mark), 6);
        check("long_long_count", n_long, 1);
        check("long_long_time", rel(t_long, mark), 26);
        check("long_rep0", rep_at(0), 31);
        check("long_rep1", rep_at(1), 36);
        check("long_rep2", rep_at(2), 41);
        check("long_rep3", rep_at(3), 46);
        check("long_rep_count", rep_q.size(), 5);
        check("long_release_time", rel(t_rel, mark), 56);
        check("long_step_count", n_step, 6);

        // Glitch shorter than the debounce window.
        cycles(5);
        clear_rec();
        btn_raw = 1'b0;
        cycles(3);
        btn_raw = 1'b1;
        cycles(12);
        check("glitch_no_level", n_level, 0);
        check("glitch_no_press", n_press, 0);
        check("glitch_no_release", n_rel, 0);

        // Asynchronous reset while in the repeat phase.
        cycles(5);
        clear_rec();
        mark    = edge_cnt;
        btn_raw = 1'b0;
        cycles(35);
        check("async_pre_level", {31'd0, level}, 32'd1);
        check("async_pre_long", n_long, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_outputs_cleared", {26'd0, level, press, release_evt, long_press, repeat_evt, step}, 32'd0);
        @(posedge clk);
        #1;
        check("async_state_idle", {30'd0, dut.state}, {30'd0, ST_IDLE});
        btn_raw = 1'b1;
        cycles(3);
        clear_rec();
        rst_n = 1'b1;
        cycles(10);
        check("post_reset_quiet", n_press + n_rel + n_long + n_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
